// File: rtl/mem_dump_if.sv
// Host/SRAM/serial-line bundle for the memory readout engine.
// The engine connects through the slave modport; the host side uses master.
interface mem_dump_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              abort;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              tx_out;
  logic              busy;
  logic              done;

  modport master (
    output start, start_addr, end_addr, abort, mem_rdata,
    input  mem_rd_en, mem_addr, tx_out, busy, done
  );

  modport slave (
    input  start, start_addr, end_addr, abort, mem_rdata,
    output mem_rd_en, mem_addr, tx_out, busy, done
  );
endinterface

// File: rtl/mem_dump_tx.sv
// Reads an inclusive, wrapping SRAM address range and sends each word LSB byte first as 8N1 frames.
// Define MEM_DUMP_CHECKSUM_EN to append a two's-complement checksum frame after the last word.
module mem_dump_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  mem_dump_if.slave  bus
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_SEND_LO, S_SEND_HI, S_CSUM, S_FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_SEND_LO, S_SEND_HI, S_FIN
  } state_t;
`endif

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic              r_tx;
  logic              r_abort;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remain;
  logic [7:0]        r_hi;
  logic [7:0]        r_shift;
  logic [3:0]        r_bit;
  logic [CNT_W-1:0]  r_cnt;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  logic w_abort;
  logic w_bit_end;
  logic w_sending;

  // A live abort counts in the same cycle it is first seen, not just once latched.
  assign w_abort   = r_abort | bus.abort;
  assign w_bit_end = (r_cnt == CNT_LAST);
`ifdef MEM_DUMP_CHECKSUM_EN
  assign w_sending = (r_state == S_SEND_LO) || (r_state == S_SEND_HI) || (r_state == S_CSUM);
`else
  assign w_sending = (r_state == S_SEND_LO) || (r_state == S_SEND_HI);
`endif

  assign bus.mem_rd_en = r_rd_en;
  assign bus.mem_addr  = r_addr;
  assign bus.tx_out    = r_tx;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_tx     <= 1'b1;
      r_abort  <= 1'b0;
      r_addr   <= '0;
      r_remain <= '0;
      r_hi     <= '0;
      r_shift  <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      r_sum    <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      if (r_busy && bus.abort) r_abort <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_abort <= 1'b0;
          if (bus.start) begin
            r_busy   <= 1'b1;
            r_rd_en  <= 1'b1;
            r_addr   <= bus.start_addr;
            r_remain <= bus.end_addr - bus.start_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
            r_sum    <= '0;
`endif
            r_state  <= S_FETCH;
          end
        end

        S_FETCH, S_WAIT: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
          end else begin
            r_state <= (r_state == S_FETCH) ? S_WAIT : S_LOAD;
          end
        end

        // SRAM data has been valid since WAIT; capture it and drop the start bit together.
        S_LOAD: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
          end else begin
            r_hi    <= bus.mem_rdata[DATA_W-1:8];
            r_shift <= bus.mem_rdata[7:0];
            r_tx    <= 1'b0;
            r_bit   <= '0;
            r_cnt   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            r_sum   <= r_sum + bus.mem_rdata[7:0];
`endif
            r_state <= S_SEND_LO;
          end
        end

        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          if (!w_sending) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
          end else if (!w_bit_end) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else if (r_bit != 4'd9) begin
            r_cnt <= '0;
            r_bit <= r_bit + 4'd1;
            if (r_bit == 4'd8) begin
              r_tx <= 1'b1;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            // End of stop bit: frame boundary, the only place an abort is honoured mid-word.
            r_cnt <= '0;
            if (w_abort) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_abort <= 1'b0;
            end else if (r_state == S_SEND_LO) begin
              r_shift <= r_hi;
              r_tx    <= 1'b0;
              r_bit   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
              r_sum   <= r_sum + r_hi;
`endif
              r_state <= S_SEND_HI;
            end else if (r_state == S_SEND_HI && r_remain != '0) begin
              r_addr   <= r_addr + ADDR_W'(1);
              r_remain <= r_remain - ADDR_W'(1);
              r_rd_en  <= 1'b1;
              r_state  <= S_FETCH;
`ifdef MEM_DUMP_CHECKSUM_EN
            end else if (r_state == S_SEND_HI) begin
              r_shift <= ~r_sum + 8'd1;
              r_tx    <= 1'b0;
              r_bit   <= '0;
              r_state <= S_CSUM;
`endif
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx: SRAM model, line receiver and per-scenario checks.
module tb_mem_dump_tx;
  localparam int C     = 4;
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int FRAME = 10 * C;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_dump_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_dump_tx #(.CLKS_PER_BIT(C), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  logic [15:0] mem [256];
  always @(posedge clk) if (bus.mem_rd_en === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];

  int n_rd   = 0;
  int n_done = 0;
  int addr_q [$];
  always @(negedge clk) begin
    if (bus.mem_rd_en === 1'b1) begin
      n_rd <= n_rd + 1;
      addr_q.push_back(int'(bus.mem_addr));
    end
    if (bus.done === 1'b1) n_done <= n_done + 1;
  end

  logic [7:0] byte_q [$];
  int         fs_q   [$];
  int         n_ferr = 0;
  initial begin : rx
    logic [7:0] b;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.tx_out === 1'b0) begin
        t0 = cyc;
        repeat (C/2) @(negedge clk);
        if (bus.tx_out !== 1'b0) n_ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = bus.tx_out;
        end
        repeat (C) @(negedge clk);
        if (bus.tx_out !== 1'b1) n_ferr++;
        byte_q.push_back(b);
        fs_q.push_back(t0);
      end
    end
  end

  task automatic do_start(input logic [7:0] sa, input logic [7:0] ea);
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = sa; bus.end_addr = ea;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit ok, output int t_idle);
    ok = 1'b0; t_idle = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin ok = 1'b1; t_idle = cyc; break; end
    end
  endtask

  task automatic test_reset();
    int base_rd, base_done;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus.tx_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.mem_rd_en); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.mem_addr); end
    rst_n = 1'b1;
    mem[0] = 16'h00F0; mem[1] = 16'h1234;
    do_start(8'd0, 8'd1);
    repeat (3 + 4*C + 1) @(negedge clk);
    // bit 4 of frame 0xF0 is data bit 3 = 0
    checks++; if (bus.tx_out !== 1'b0) begin errors++; $display("FAIL reset_midframe_tx: got %b want 0", bus.tx_out); end
    base_done = n_done;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.tx_out !== 1'b1) begin errors++; $display("FAIL reset_async_tx: got %b want 1", bus.tx_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_async_busy: got %b want 0", bus.busy); end
    checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_async_rd: got %b want 0", bus.mem_rd_en); end
    base_rd = n_rd;
    repeat (FRAME + 10) @(negedge clk);
    checks++; if (n_done !== base_done) begin errors++; $display("FAIL reset_no_done: got %0d want %0d", n_done, base_done); end
    checks++; if (n_rd !== base_rd) begin errors++; $display("FAIL reset_no_reads: got %0d want %0d", n_rd, base_rd); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_hold_addr: got %0h want 0", bus.mem_addr); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [7:0] fb [3];
    logic [7:0] cur;
    logic       etx;
    int nframes, last, f, bi, b0, d0, r0, e0;
    fb[0] = 8'hA5; fb[1] = 8'h12; fb[2] = 8'h49;
`ifdef MEM_DUMP_CHECKSUM_EN
    nframes = 3;
`else
    nframes = 2;
`endif
    last = 3 + nframes * FRAME;
    b0 = byte_q.size(); d0 = n_done; r0 = n_rd; e0 = n_ferr;
    mem[3] = 16'h12A5;
    do_start(8'd3, 8'd3);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_set: got %b want 1", bus.busy); end
    checks++; if (bus.mem_rd_en !== 1'b1) begin errors++; $display("FAIL single_fetch_rd: got %b want 1", bus.mem_rd_en); end
    checks++; if (bus.mem_addr !== 8'd3) begin errors++; $display("FAIL single_fetch_addr: got %0d want 3", bus.mem_addr); end
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      if (k < 3 || k >= last) etx = 1'b1;
      else begin
        f   = (k - 3) / FRAME;
        bi  = ((k - 3) % FRAME) / C;
        cur = fb[f];
        etx = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : cur[bi-1];
      end
      checks++; if (bus.tx_out !== etx) begin errors++; $display("FAIL single_tx k=%0d: got %b want %b", k, bus.tx_out, etx); end
      checks++; if (bus.done !== (k == last)) begin errors++; $display("FAIL single_done k=%0d: got %b want %b", k, bus.done, (k == last)); end
      checks++; if (bus.busy !== (k <= last)) begin errors++; $display("FAIL single_busy k=%0d: got %b want %b", k, bus.busy, (k <= last)); end
      checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL single_rd k=%0d: got %b want 0", k, bus.mem_rd_en); end
    end
    repeat (2) @(negedge clk);
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", n_done - d0); end
    checks++; if (n_rd - r0 !== 1) begin errors++; $display("FAIL single_rd_count: got %0d want 1", n_rd - r0); end
    checks++; if (byte_q.size() - b0 !== nframes) begin errors++; $display("FAIL single_frames: got %0d want %0d", byte_q.size() - b0, nframes); end
    checks++; if (n_ferr !== e0) begin errors++; $display("FAIL single_framing: got %0d want %0d", n_ferr - e0, 0); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [$];
    logic [7:0] got, sum;
    int ea [4];
    int b0, a0, d0, e0, t_idle, gap, eg;
    bit ok;
    ea[0] = 254; ea[1] = 255; ea[2] = 0; ea[3] = 1;
    mem[254] = 16'hBEEF; mem[255] = 16'h1357; mem[0] = 16'h2468; mem[1] = 16'hC0DE;
    exp = '{8'hEF, 8'hBE, 8'h57, 8'h13, 8'h68, 8'h24, 8'hDE, 8'hC0};
    sum = 8'h00;
    foreach (exp[i]) sum = sum + exp[i];
`ifdef MEM_DUMP_CHECKSUM_EN
    exp.push_back(8'h00 - sum);
`endif
    b0 = byte_q.size(); a0 = addr_q.size(); d0 = n_done; e0 = n_ferr;
    do_start(8'd254, 8'd1);
    wait_idle(4 * (3 + 2*FRAME) + FRAME + 20, ok, t_idle);
    repeat (2) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: busy still %b", bus.busy); end
    checks++; if (addr_q.size() - a0 !== 4) begin errors++; $display("FAIL wrap_reads: got %0d want 4", addr_q.size() - a0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a0 + i >= addr_q.size() || addr_q[a0+i] !== ea[i]) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, (a0 + i < addr_q.size()) ? addr_q[a0+i] : -1, ea[i]);
      end
    end
    checks++; if (byte_q.size() - b0 !== exp.size()) begin errors++; $display("FAIL wrap_frames: got %0d want %0d", byte_q.size() - b0, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (b0 + i < byte_q.size()) ? byte_q[b0+i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL wrap_byte[%0d]: got %0h want %0h", i, got, exp[i]); end
    end
    for (int i = 1; i < exp.size() && b0 + i < fs_q.size(); i++) begin
      gap = fs_q[b0+i] - fs_q[b0+i-1];
      eg  = (i % 2 == 1 || i == 8) ? FRAME : FRAME + 3;
      checks++; if (gap !== eg) begin errors++; $display("FAIL wrap_gap[%0d]: got %0d want %0d", i, gap, eg); end
    end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL wrap_done: got %0d want 1", n_done - d0); end
    checks++; if (n_ferr !== e0) begin errors++; $display("FAIL wrap_framing: got %0d want 0", n_ferr - e0); end
  endtask

  task automatic test_abort();
    int b0, r0, d0, t_idle;
    bit ok;
    for (int i = 0; i < 10; i++) mem[i] = 16'h5A30 + 16'(i);
    b0 = byte_q.size(); r0 = n_rd; d0 = n_done;
    do_start(8'd0, 8'd9);
    repeat (3) @(negedge clk);
    checks++; if (bus.tx_out !== 1'b0) begin errors++; $display("FAIL abort_fall: got %b want 0", bus.tx_out); end
    repeat (17) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_idle(FRAME + 20, ok, t_idle);
    checks++; if (!ok) begin errors++; $display("FAIL abort_timeout: busy still %b", bus.busy); end
    checks++; if (bus.tx_out !== 1'b1) begin errors++; $display("FAIL abort_line_idle: got %b want 1", bus.tx_out); end
    repeat (FRAME) @(negedge clk);
    checks++; if (fs_q.size() <= b0 || t_idle - fs_q[fs_q.size()-1] !== FRAME) begin
      errors++; $display("FAIL abort_idle_time: got %0d want %0d", (fs_q.size() > b0) ? t_idle - fs_q[fs_q.size()-1] : -1, FRAME);
    end
    checks++; if (byte_q.size() - b0 !== 1) begin errors++; $display("FAIL abort_frames: got %0d want 1", byte_q.size() - b0); end
    checks++; if (byte_q.size() <= b0 || byte_q[b0] !== 8'h30) begin
      errors++; $display("FAIL abort_byte: got %0h want 30", (byte_q.size() > b0) ? byte_q[b0] : 8'hxx);
    end
    checks++; if (n_rd - r0 !== 1) begin errors++; $display("FAIL abort_reads: got %0d want 1", n_rd - r0); end
    checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL abort_done: got %0d want 0", n_done - d0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_busy_collision();
    logic [7:0] exp [$];
    logic [7:0] got, sum;
    int b0, a0, d0, t_idle;
    bit ok;
    mem[10] = 16'hA10B; mem[11] = 16'h0C0D;
    for (int i = 20; i <= 30; i++) mem[i] = 16'hEE00 + 16'(i);
    exp = '{8'h0B, 8'hA1, 8'h0D, 8'h0C};
    sum = 8'h00;
    foreach (exp[i]) sum = sum + exp[i];
`ifdef MEM_DUMP_CHECKSUM_EN
    exp.push_back(8'h00 - sum);
`endif
    b0 = byte_q.size(); a0 = addr_q.size(); d0 = n_done;
    do_start(8'd10, 8'd11);
    repeat (30) @(negedge clk);
    do_start(8'd20, 8'd30);
    checks++; if (bus.mem_addr !== 8'd10) begin errors++; $display("FAIL collide_addr_kept: got %0d want 10", bus.mem_addr); end
    wait_idle(2 * (3 + 2*FRAME) + FRAME + 20, ok, t_idle);
    repeat (2) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL collide_timeout: busy still %b", bus.busy); end
    checks++; if (addr_q.size() - a0 !== 2) begin errors++; $display("FAIL collide_reads: got %0d want 2", addr_q.size() - a0); end
    checks++; if (addr_q.size() < a0 + 2 || addr_q[a0] !== 10 || addr_q[a0+1] !== 11) begin
      errors++; $display("FAIL collide_addr_seq: got %0d entries want 10,11", addr_q.size() - a0);
    end
    checks++; if (byte_q.size() - b0 !== exp.size()) begin errors++; $display("FAIL collide_frames: got %0d want %0d", byte_q.size() - b0, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (b0 + i < byte_q.size()) ? byte_q[b0+i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL collide_byte[%0d]: got %0h want %0h", i, got, exp[i]); end
    end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL collide_done: got %0d want 1", n_done - d0); end
  endtask

`ifdef MEM_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] exp [5];
    logic [7:0] got;
    int b0, d0, t_idle;
    bit ok;
    mem[5] = 16'h0102; mem[6] = 16'h0304;
    exp[0] = 8'h02; exp[1] = 8'h01; exp[2] = 8'h04; exp[3] = 8'h03; exp[4] = 8'hF6;
    b0 = byte_q.size(); d0 = n_done;
    do_start(8'd5, 8'd6);
    wait_idle(2 * (3 + 2*FRAME) + FRAME + 20, ok, t_idle);
    repeat (2) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL csum_timeout: busy still %b", bus.busy); end
    checks++; if (byte_q.size() - b0 !== 5) begin errors++; $display("FAIL csum_frames: got %0d want 5", byte_q.size() - b0); end
    for (int i = 0; i < 5; i++) begin
      got = (b0 + i < byte_q.size()) ? byte_q[b0+i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL csum_byte[%0d]: got %0h want %0h", i, got, exp[i]); end
    end
    checks++; if (fs_q.size() < b0 + 5 || t_idle - fs_q[b0+4] !== FRAME + 1) begin
      errors++; $display("FAIL csum_done_time: got %0d want %0d", (fs_q.size() >= b0 + 5) ? t_idle - fs_q[b0+4] : -1, FRAME + 1);
    end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL csum_done: got %0d want 1", n_done - d0); end
  endtask
`endif

  task automatic test_full_range();
    logic [7:0] exp [$];
    logic [7:0] got, sum;
    int b0, a0, r0, d0, t_idle;
    bit ok;
    sum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {8'(i), 8'(255 - i)};
      exp.push_back(8'(255 - i));
      exp.push_back(8'(i));
      sum = sum + 8'(255 - i) + 8'(i);
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    exp.push_back(8'h00 - sum);
`endif
    b0 = byte_q.size(); a0 = addr_q.size(); r0 = n_rd; d0 = n_done;
    do_start(8'd0, 8'd255);
    wait_idle(256 * (3 + 2*FRAME) + FRAME + 50, ok, t_idle);
    repeat (2) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout: busy still %b", bus.busy); end
    checks++; if (n_rd - r0 !== 256) begin errors++; $display("FAIL full_reads: got %0d want 256", n_rd - r0); end
    checks++; if (addr_q.size() < a0 + 256 || addr_q[a0] !== 0 || addr_q[a0+255] !== 255) begin
      errors++; $display("FAIL full_addr_ends: got %0d reads want 0..255", addr_q.size() - a0);
    end
    checks++; if (byte_q.size() - b0 !== exp.size()) begin errors++; $display("FAIL full_frames: got %0d want %0d", byte_q.size() - b0, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (b0 + i < byte_q.size()) ? byte_q[b0+i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL full_byte[%0d]: got %0h want %0h", i, got, exp[i]); end
    end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL full_done: got %0d want 1", n_done - d0); end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.start_addr = '0; bus.end_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_single_word();
    test_wrap();
    test_abort();
    test_busy_collision();
`ifdef MEM_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    test_full_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
